mvb_item_repacker: RTL

- Item-granular MVB reshaper: accepts RX words of RX_ITEMS lanes with arbitrary VLD gaps and emits TX words of TX_ITEMS lanes, packed from lane 0 upward with no gaps.
- Order-preserving; the RX and TX item counts are independent, so the block can act as an up-converter or a down-converter.
- Sits between MVB producers (parsers, hash units) and consumers needing dense words.
- Optional full-word mode holds partial words until full, with a timeout that flushes stragglers.

---
 rtl/mvb_item_repacker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mvb_item_repacker.sv
// Item-granular MVB reshaper: gathers valid RX items into a circular buffer and
// presents them densely packed on TX words, with optional full-word/timeout mode.

module mvb_item_repacker_tx_lane #(
  parameter int LANE       = 0,
  parameter int ITEM_WIDTH = 32,
  parameter int BUF_ITEMS  = 8,
  parameter int PTR_W      = 3,
  parameter int CNT_W      = 4
) (
  input  logic [BUF_ITEMS-1:0][ITEM_WIDTH-1:0] mem,
  input  logic [PTR_W-1:0]                     rd_ptr,
  input  logic [CNT_W-1:0]                     n,
  output logic                                 vld,
  output logic [ITEM_WIDTH-1:0]                data
);
  logic [PTR_W:0]   idx_sum;
  logic [PTR_W-1:0] idx;

  // LANE < BUF_ITEMS, so one conditional subtract is a full modulo
  assign idx_sum = {1'b0, rd_ptr} + (PTR_W+1)'(LANE);
  assign idx     = (idx_sum >= (PTR_W+1)'(BUF_ITEMS)) ? PTR_W'(idx_sum - (PTR_W+1)'(BUF_ITEMS))
                                                      : PTR_W'(idx_sum);
  assign vld     = CNT_W'(LANE) < n;
  assign data    = vld ? mem[idx] : '0;
endmodule

module mvb_item_repacker #(
  parameter int RX_ITEMS   = 4,
  parameter int TX_ITEMS   = 2,
  parameter int ITEM_WIDTH = 32,
  parameter int BUF_ITEMS  = 8,
  parameter int FULL_ONLY  = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [RX_ITEMS*ITEM_WIDTH-1:0]      RX_DATA,
  input  logic [RX_ITEMS-1:0]                 RX_VLD,
  input  logic                                RX_SRC_RDY,
  output logic                                RX_DST_RDY,
  output logic [TX_ITEMS*ITEM_WIDTH-1:0]      TX_DATA,
  output logic [TX_ITEMS-1:0]                 TX_VLD,
  output logic                                TX_SRC_RDY,
  input  logic                                TX_DST_RDY,
  output logic [$clog2(BUF_ITEMS+1)-1:0]      STATUS_ITEMS
);
  localparam int PTR_W    = $clog2(BUF_ITEMS);
  localparam int CNT_W    = $clog2(BUF_ITEMS+1);
  localparam int TMR_W    = $clog2(TIMEOUT+2);
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT-1 : 0;

  if (BUF_ITEMS < RX_ITEMS + TX_ITEMS) begin : g_cfg_err
    $error("mvb_item_repacker: BUF_ITEMS must be >= RX_ITEMS+TX_ITEMS");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_t;

  logic [BUF_ITEMS-1:0][ITEM_WIDTH-1:0] mem;
  logic [RX_ITEMS-1:0][ITEM_WIDTH-1:0]  rx_items;
  logic [TX_ITEMS-1:0][ITEM_WIDTH-1:0]  tx_items;
  logic [RX_ITEMS-1:0][CNT_W-1:0]       rx_pos;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt, cnt_next, n, rx_num;
  logic             rx_xfer, tx_xfer, rx_hit, flush;
  state_t           state, state_next;
  logic [TMR_W-1:0] timer, timer_next;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] d);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(d);
    return (s >= (PTR_W+1)'(BUF_ITEMS)) ? PTR_W'(s - (PTR_W+1)'(BUF_ITEMS)) : PTR_W'(s);
  endfunction

  assign rx_items = RX_DATA;

  // Each valid lane lands at wr_ptr + (number of valid lanes below it)
  always_comb begin
    rx_num = '0;
    rx_pos = '0;
    for (int i = 0; i < RX_ITEMS; i++) begin
      rx_pos[i] = rx_num;
      rx_num    = rx_num + CNT_W'(RX_VLD[i]);
    end
  end

  assign n          = (cnt < CNT_W'(TX_ITEMS)) ? cnt : CNT_W'(TX_ITEMS);
  assign RX_DST_RDY = !RESET && (cnt <= CNT_W'(BUF_ITEMS - RX_ITEMS));
  assign rx_xfer    = RX_SRC_RDY && RX_DST_RDY;
  assign tx_xfer    = TX_SRC_RDY && TX_DST_RDY;
  assign rx_hit     = rx_xfer && (rx_num != '0);
  assign cnt_next   = cnt + (rx_xfer ? rx_num : '0) - (tx_xfer ? n : '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      cnt <= cnt_next;
      if (rx_xfer) wr_ptr <= wrap_add(wr_ptr, rx_num);
      if (tx_xfer) rd_ptr <= wrap_add(rd_ptr, n);
    end
  end

  always_ff @(posedge CLK) begin
    if (rx_xfer)
      for (int i = 0; i < RX_ITEMS; i++)
        if (RX_VLD[i]) mem[wrap_add(wr_ptr, rx_pos[i])] <= rx_items[i];
  end

  for (genvar g = 0; g < TX_ITEMS; g++) begin : g_lane
    mvb_item_repacker_tx_lane #(
      .LANE(g), .ITEM_WIDTH(ITEM_WIDTH), .BUF_ITEMS(BUF_ITEMS), .PTR_W(PTR_W), .CNT_W(CNT_W)
    ) u_lane (
      .mem(mem), .rd_ptr(rd_ptr), .n(n), .vld(TX_VLD[g]), .data(tx_items[g])
    );
  end

  assign TX_DATA      = tx_items;
  assign STATUS_ITEMS = cnt;

  // Timeout FSM: state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Timeout FSM: next state; timer only runs on a starved partial word
  always_comb begin
    state_next = S_IDLE;
    timer_next = '0;
    if (FULL_ONLY != 0) begin
      if (cnt_next == '0)
        state_next = S_IDLE;
      else if (state == S_FLUSH && !tx_xfer)
        state_next = S_FLUSH;
      else if (TIMEOUT != 0 && state == S_WAIT && !rx_hit && cnt < CNT_W'(TX_ITEMS) &&
               timer == TMR_W'(TMO_LAST))
        state_next = S_FLUSH;
      else begin
        state_next = S_WAIT;
        if (state == S_WAIT && !rx_hit && cnt_next < CNT_W'(TX_ITEMS) && TIMEOUT != 0)
          timer_next = timer + 1'b1;
      end
    end
  end

  // Timeout FSM: outputs
  always_comb begin
    flush      = (state == S_FLUSH);
    TX_SRC_RDY = (FULL_ONLY != 0) ? ((cnt >= CNT_W'(TX_ITEMS)) || flush) : (cnt != '0);
  end
endmodule
